// File: rtl/ntt_sched_pkg.sv
// Shared definitions for the NTT core scheduler: FSM state encoding and default sizes.
package ntt_sched_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_REQ_ID_W = 2;
  localparam int WDOG_W       = 13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ntt_sched_arb_if.sv
// Requester/core handshake bundle for ntt_sched_arb; o_timeout exists only with NTT_SCHED_WDOG_EN.
interface ntt_sched_arb_if
  import ntt_sched_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int REQ_ID_W = DEF_REQ_ID_W
);
  logic [NUM_REQ-1:0]  i_req;
  logic [NUM_REQ-1:0]  o_gnt;
  logic [NUM_REQ-1:0]  o_done;
  logic [REQ_ID_W-1:0] o_sel;
  logic                o_ntt_start;
  logic                i_ntt_done;
  logic                o_busy;
`ifdef NTT_SCHED_WDOG_EN
  logic                o_timeout;
`endif

  modport master (
    output i_req, i_ntt_done,
    input  o_gnt, o_done, o_sel, o_ntt_start, o_busy
`ifdef NTT_SCHED_WDOG_EN
    , input o_timeout
`endif
  );

  modport slave (
    input  i_req, i_ntt_done,
    output o_gnt, o_done, o_sel, o_ntt_start, o_busy
`ifdef NTT_SCHED_WDOG_EN
    , output o_timeout
`endif
  );
endinterface

// File: rtl/ntt_rr_pick.sv
// Combinational rotate-priority encoder: first set req bit scanning upward from ptr+1 (mod NUM_REQ).
module ntt_rr_pick
  import ntt_sched_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int REQ_ID_W = DEF_REQ_ID_W
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_ID_W-1:0] ptr,
  output logic                valid,
  output logic [REQ_ID_W-1:0] index,
  output logic [NUM_REQ-1:0]  onehot
);

  logic [REQ_ID_W-1:0] cand_s;

  // Walk the rotated order; the first hit wins and later hits are masked by valid.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    cand_s = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = REQ_ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand_s]) begin
        valid          = 1'b1;
        index          = cand_s;
        onehot[cand_s] = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/ntt_sched_arb.sv
// Round-robin scheduler sharing one ntt_core among NUM_REQ requesters.
// Optional RUN watchdog with sticky o_timeout is enabled by NTT_SCHED_WDOG_EN.
module ntt_sched_arb
  import ntt_sched_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int REQ_ID_W     = DEF_REQ_ID_W,
  parameter int SETUP_CYCLES = 2
`ifdef NTT_SCHED_WDOG_EN
  ,
  parameter int WDOG_CYCLES  = 4096
`endif
) (
  input logic            clk,
  input logic            rst_n,
  ntt_sched_arb_if.slave bus
);

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic [REQ_ID_W-1:0] ptr_r, ptr_s;
  logic [REQ_ID_W-1:0] sel_r, sel_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic [NUM_REQ-1:0]  done_r, done_s;
  logic                start_r, start_s;
  logic                busy_r, busy_s;
  logic                pick_valid_s;
  logic [REQ_ID_W-1:0] pick_idx_s;
  logic [NUM_REQ-1:0]  pick_oh_s;
`ifdef NTT_SCHED_WDOG_EN
  logic [WDOG_W-1:0]   wcnt_r, wcnt_s;
  logic                timeout_r, timeout_s;
`endif

  ntt_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .REQ_ID_W (REQ_ID_W)
  ) u_pick (
    .req    (bus.i_req),
    .ptr    (ptr_r),
    .valid  (pick_valid_s),
    .index  (pick_idx_s),
    .onehot (pick_oh_s)
  );

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    sel_s   = sel_r;
    gnt_s   = gnt_r;
`ifdef NTT_SCHED_WDOG_EN
    wcnt_s    = wcnt_r;
    timeout_s = timeout_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (pick_valid_s) begin
          sel_s   = pick_idx_s;
          gnt_s   = pick_oh_s;
          cnt_s   = 4'd0;
          state_s = S_SETUP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_r == 4'(SETUP_CYCLES - 1)) begin
          state_s = S_START;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      S_START: begin
        state_s = S_RUN;
`ifdef NTT_SCHED_WDOG_EN
        wcnt_s  = '0;
`endif
      end
      S_RUN: begin
        if (bus.i_ntt_done) begin
          state_s = S_DONE;
`ifdef NTT_SCHED_WDOG_EN
        end else if (wcnt_r == WDOG_W'(WDOG_CYCLES)) begin
          state_s   = S_DONE;
          timeout_s = 1'b1;
        end else begin
          wcnt_s = wcnt_r + {{(WDOG_W-1){1'b0}}, 1'b1};
`else
        end else begin
          state_s = S_RUN;
`endif
        end
      end
      S_DONE: begin
        ptr_s   = sel_r;
        gnt_s   = '0;
        state_s = S_IDLE;
      end
      default: begin
        gnt_s   = '0;
        state_s = S_IDLE;
      end
    endcase
    start_s = (state_s == S_START);
    done_s  = (state_s == S_DONE) ? gnt_s : '0;
    busy_s  = (state_s != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= 4'd0;
      ptr_r     <= '0;
      sel_r     <= '0;
      gnt_r     <= '0;
      done_r    <= '0;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
`ifdef NTT_SCHED_WDOG_EN
      wcnt_r    <= '0;
      timeout_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      ptr_r     <= ptr_s;
      sel_r     <= sel_s;
      gnt_r     <= gnt_s;
      done_r    <= done_s;
      start_r   <= start_s;
      busy_r    <= busy_s;
`ifdef NTT_SCHED_WDOG_EN
      wcnt_r    <= wcnt_s;
      timeout_r <= timeout_s;
`endif
    end
  end

  assign bus.o_gnt       = gnt_r;
  assign bus.o_done      = done_r;
  assign bus.o_sel       = sel_r;
  assign bus.o_ntt_start = start_r;
  assign bus.o_busy      = busy_r;
`ifdef NTT_SCHED_WDOG_EN
  assign bus.o_timeout   = timeout_r;
`endif

endmodule
